midi_poly_synth: RTL and testbench

Polyphonic MIDI-to-square-wave synthesiser. It replaces the single-voice, one-octave synth with a byte-level MIDI parser, `VOICES` independent square-wave oscillators and a voice allocator. It covers the full note range 0–127 on one selectable channel. It sits between the UART receiver (`received`/`rx_byte`) and the `buzz` pin.

---
 rtl/midi_pkg.sv | 43 ++++
 rtl/square_voice.sv | 50 +++++
 rtl/midi_poly_synth.sv | 225 ++++++++++++++++++++++
 tb/tb_midi_poly_synth.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package     : midi_pkg                                             |
// | Description : MIDI status constants, parser state encoding and the |
// |               base (octave 0) period table for the poly synth.     |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package midi_pkg;

  localparam logic [3:0] NOTE_ON      = 4'h9;
  localparam logic [3:0] NOTE_OFF     = 4'h8;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA1 = 2'd1,
    ST_DATA2 = 2'd2
  } parse_state_t;

  // Clock ticks per cycle of MIDI notes 0..11, rounded to nearest.
  // Frequencies are held in nanohertz so the division stays in integers.
  function automatic logic [31:0] base_period(input longint unsigned clk_hz,
                                              input int unsigned      semitone);
    longint unsigned f_nhz;
    case (semitone)
      0:       f_nhz = 64'd8175798916;
      1:       f_nhz = 64'd8661957218;
      2:       f_nhz = 64'd9177023997;
      3:       f_nhz = 64'd9722718241;
      4:       f_nhz = 64'd10300861154;
      5:       f_nhz = 64'd10913382232;
      6:       f_nhz = 64'd11562325710;
      7:       f_nhz = 64'd12249857374;
      8:       f_nhz = 64'd12978271799;
      9:       f_nhz = 64'd13750000000;
      10:      f_nhz = 64'd14567617547;
      default: f_nhz = 64'd15433853164;
    endcase
    return 32'((clk_hz * 64'd1000000000 + f_nhz / 64'd2) / f_nhz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/square_voice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : square_voice                                         |
// | Description : One square-wave oscillator. A load restarts the      |
// |               phase at 0 with a new period/high time; off silences |
// |               it and parks the counter at 0.                       |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module square_voice #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                off,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] high_ticks,
  output logic                out
);

  logic                r_run;
  logic [PERIOD_W-1:0] r_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] r_high;

  // Phase counter: 0..period-1 while running, held at 0 when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_high   <= '0;
    end else if (load) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_period <= period;
      r_high   <= high_ticks;
    end else if (off) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (r_run) begin
      if (r_cnt == r_period - PERIOD_W'(1)) r_cnt <= '0;
      else                                  r_cnt <= r_cnt + PERIOD_W'(1);
    end
  end

  assign out = r_run && (r_cnt < r_high);

endmodule
`default_nettype wire

// File: rtl/midi_poly_synth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : midi_poly_synth                                      |
// | Description : Byte-level MIDI parser, voice allocator and VOICES   |
// |               square-wave oscillators OR'd onto the buzz pin.      |
// |               Define MIDI_POLY_SYNTH_VELOCITY_DUTY_EN to scale the |
// |               duty cycle by note velocity (default: fixed 50%).    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module midi_poly_synth
  import midi_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int VOICES   = 4,
  parameter int CHANNEL  = 0,
  parameter int PERIOD_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              buzz,
  output logic [VOICES-1:0] voice_active
);

  localparam int          c_IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [3:0]  c_CHAN  = 4'(CHANNEL);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(VOICES - 1);
  localparam logic [31:0] c_base_period [16] = '{
    base_period(64'(CLK_HZ), 0), base_period(64'(CLK_HZ), 1),
    base_period(64'(CLK_HZ), 2), base_period(64'(CLK_HZ), 3),
    base_period(64'(CLK_HZ), 4), base_period(64'(CLK_HZ), 5),
    base_period(64'(CLK_HZ), 6), base_period(64'(CLK_HZ), 7),
    base_period(64'(CLK_HZ), 8), base_period(64'(CLK_HZ), 9),
    base_period(64'(CLK_HZ), 10), base_period(64'(CLK_HZ), 11),
    32'd0, 32'd0, 32'd0, 32'd0
  };

  // Parser state
  parse_state_t r_state, w_state_nxt;
  logic         r_run_vld, w_run_vld_nxt;  // running status present
  logic         r_run_on,  w_run_on_nxt;   // running status is 0x9n
  logic [6:0]   r_note,    w_note_nxt;
  logic         r_event,   w_event_nxt;
  logic         r_ev_on,   w_ev_on_nxt;

  // Voice bookkeeping
  logic [VOICES-1:0]  r_active;
  logic [6:0]         r_vnote [VOICES];
  logic [c_IDX_W-1:0] r_steal_ptr;
  logic               r_buzz;

  logic               w_hit, w_free, w_steal;
  logic [c_IDX_W-1:0] w_hit_idx, w_free_idx;
  logic [VOICES-1:0]  w_load, w_off, w_vout;
  logic [3:0]         w_octave, w_semi;
  logic [PERIOD_W-1:0] w_period, w_high;

  // Parser registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_run_vld <= 1'b0;
      r_run_on  <= 1'b0;
      r_note    <= '0;
      r_event   <= 1'b0;
      r_ev_on   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_vld <= w_run_vld_nxt;
      r_run_on  <= w_run_on_nxt;
      r_note    <= w_note_nxt;
      r_event   <= w_event_nxt;
      r_ev_on   <= w_ev_on_nxt;
    end
  end

  // Parser next state: status bytes set/clear running status, data bytes
  // walk note -> velocity; real-time bytes leave everything untouched
  always_comb begin
    w_state_nxt   = r_state;
    w_run_vld_nxt = r_run_vld;
    w_run_on_nxt  = r_run_on;
    w_note_nxt    = r_note;
    w_event_nxt   = 1'b0;
    w_ev_on_nxt   = r_ev_on;
    if (rx_valid && (rx_byte < REALTIME_MIN)) begin
      if (rx_byte[7]) begin
        if ((rx_byte[3:0] == c_CHAN) &&
            ((rx_byte[7:4] == NOTE_ON) || (rx_byte[7:4] == NOTE_OFF))) begin
          w_run_vld_nxt = 1'b1;
          w_run_on_nxt  = (rx_byte[7:4] == NOTE_ON);
          w_state_nxt   = ST_DATA1;
        end else begin
          w_run_vld_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_run_vld) begin
              w_note_nxt  = rx_byte[6:0];
              w_state_nxt = ST_DATA2;
            end
          end
          ST_DATA1: begin
            w_note_nxt  = rx_byte[6:0];
            w_state_nxt = ST_DATA2;
          end
          ST_DATA2: begin
            w_event_nxt = 1'b1;
            w_ev_on_nxt = r_run_on && (rx_byte[6:0] != 7'd0);
            w_state_nxt = ST_DATA1;
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // Octave/semitone split of the pending note by a compare chain
  always_comb begin
    w_octave = 4'd0;
    w_semi   = r_note[3:0];
    for (int k = 1; k <= 10; k++) begin
      if (r_note >= 7'(12 * k)) begin
        w_octave = 4'(k);
        w_semi   = 4'(r_note - 7'(12 * k));
      end
    end
  end

  assign w_period = PERIOD_W'(c_base_period[w_semi] >> w_octave);

`ifdef MIDI_POLY_SYNTH_VELOCITY_DUTY_EN
  logic [6:0]          r_vel;
  logic [PERIOD_W+6:0] w_prod;

  // Velocity of the message being completed, used to scale duty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vel <= '0;
    else if (rx_valid && !rx_byte[7] && (r_state == ST_DATA2)) r_vel <= rx_byte[6:0];
  end

  assign w_prod = (PERIOD_W+7)'(w_period) * (PERIOD_W+7)'(r_vel);
  assign w_high = PERIOD_W'(w_prod >> 8);
`else
  assign w_high = w_period >> 1;
`endif

  // Allocation: retrigger a holder, else lowest free voice, else steal
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    w_load     = '0;
    w_off      = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (r_active[i] && (r_vnote[i] == r_note)) begin
        w_hit     = 1'b1;
        w_hit_idx = c_IDX_W'(i);
      end
      if (!r_active[i]) begin
        w_free     = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
    end
    if (r_event) begin
      if (r_ev_on) begin
        if (w_hit)       w_load[w_hit_idx]   = 1'b1;
        else if (w_free) w_load[w_free_idx]  = 1'b1;
        else             w_load[r_steal_ptr] = 1'b1;
      end else begin
        for (int i = 0; i < VOICES; i++)
          if (r_active[i] && (r_vnote[i] == r_note)) w_off[i] = 1'b1;
      end
    end
    w_steal = r_event && r_ev_on && !w_hit && !w_free;
  end

  // Per-voice note/active registers and the round-robin steal pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active    <= '0;
      r_steal_ptr <= '0;
      for (int i = 0; i < VOICES; i++) r_vnote[i] <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (w_load[i]) begin
          r_active[i] <= 1'b1;
          r_vnote[i]  <= r_note;
        end else if (w_off[i]) begin
          r_active[i] <= 1'b0;
        end
      end
      if (w_steal) r_steal_ptr <= (r_steal_ptr == c_LAST) ? '0 : r_steal_ptr + c_IDX_W'(1);
    end
  end

  generate
    for (genvar g = 0; g < VOICES; g++) begin : g_voice
      square_voice #(.PERIOD_W(PERIOD_W)) u_voice (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load[g]),
        .off        (w_off[g]),
        .period     (w_period),
        .high_ticks (w_high),
        .out        (w_vout[g])
      );
    end
  endgenerate

  // Registered mix of all voices onto the pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_buzz <= 1'b0;
    else     r_buzz <= |w_vout;
  end

  assign buzz         = r_buzz;
  assign voice_active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_midi_poly_synth.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_midi_poly_synth                                   |
// | Description : Self-checking bench for midi_poly_synth with a       |
// |               behavioural MIDI/allocator model and tone timing.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_midi_poly_synth;

  localparam int CLK_HZ   = 12000000;
  localparam int VOICES   = 4;
  localparam int CHANNEL  = 0;
  localparam int PERIOD_W = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              buzz;
  logic [VOICES-1:0] voice_active;

  int n_tests = 0;
  int n_fail  = 0;

  midi_poly_synth #(
    .CLK_HZ(CLK_HZ), .VOICES(VOICES), .CHANNEL(CHANNEL), .PERIOD_W(PERIOD_W)
  ) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .buzz(buzz), .voice_active(voice_active)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_act [VOICES];
  int m_vn  [VOICES];
  int m_ptr, m_run, m_stage, m_note;

  function automatic void model_reset();
    for (int i = 0; i < VOICES; i++) begin m_act[i] = 0; m_vn[i] = 0; end
    m_ptr = 0; m_run = -1; m_stage = 0; m_note = 0;
  endfunction

  function automatic void model_event(int note, bit on);
    int v = -1;
    for (int i = 0; i < VOICES; i++) if (m_act[i] && m_vn[i] == note) v = i;
    if (on) begin
      if (v < 0) for (int i = VOICES - 1; i >= 0; i--) if (!m_act[i]) v = i;
      if (v < 0) begin v = m_ptr; m_ptr = (m_ptr + 1) % VOICES; end
      m_act[v] = 1; m_vn[v] = note;
    end else if (v >= 0) begin
      m_act[v] = 0;
    end
  endfunction

  function automatic void model_byte(int b);
    if (b >= 'hF8) return;
    if (b >= 'h80) begin
      if ((((b >> 4) == 9) || ((b >> 4) == 8)) && ((b & 15) == CHANNEL)) begin
        m_run = b; m_stage = 1;
      end else begin
        m_run = -1; m_stage = 0;
      end
    end else if (m_stage == 2) begin
      model_event(m_note, ((m_run >> 4) == 9) && (b != 0));
      m_stage = 1;
    end else if (m_stage == 1 || m_run >= 0) begin
      m_note = b; m_stage = 2;
    end
  endfunction

  function automatic logic [VOICES-1:0] model_vec();
    logic [VOICES-1:0] r;
    for (int i = 0; i < VOICES; i++) r[i] = m_act[i];
    return r;
  endfunction

  function automatic int exp_period(int note);
    real f;
    int  base;
    f    = 440.0 * $pow(2.0, (real'(note % 12) - 69.0) / 12.0);
    base = $rtoi(real'(CLK_HZ) / f + 0.5);
    return base >> (note / 12);
  endfunction

  function automatic int exp_high(int note, int vel);
    int h;
    h = (vel == 0) ? 0 : (exp_period(note) >> 1);
`ifdef MIDI_POLY_SYNTH_VELOCITY_DUTY_EN
    h = (exp_period(note) * vel) >> 8;
`endif
    return h;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_byte = b; model_byte(int'(b));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic measure_tone(input int note, input int vel, input string name);
    int h, l, eh, ep;
    eh = exp_high(note, vel);
    ep = exp_period(note);
    h = 0;
    while (buzz === 1'b1 && h < 40000) begin h++; @(negedge clk); end
    l = 0;
    while (buzz === 1'b0 && l < 40000) begin l++; @(negedge clk); end
    n_tests++;
    if (h !== eh) begin n_fail++; $display("FAIL %s_high: got %0d expected %0d", name, h, eh); end
    n_tests++;
    if (h + l !== ep) begin n_fail++; $display("FAIL %s_period: got %0d expected %0d", name, h + l, ep); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (buzz !== 1'b0 || voice_active !== '0) begin
      n_fail++; $display("FAIL reset_in: buzz=%b active=%b expected 0/0000", buzz, voice_active);
    end
    rst = 1'b0; model_reset();
    settle();
    n_tests++;
    if (buzz !== 1'b0 || voice_active !== '0) begin
      n_fail++; $display("FAIL reset_out: buzz=%b active=%b expected 0/0000", buzz, voice_active);
    end
  endtask

  task automatic test_note_on_69();
    do_reset();
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h64);
    n_tests++;
    if (voice_active !== 4'b0000) begin n_fail++; $display("FAIL lat_event: active=%b expected 0000", voice_active); end
    @(negedge clk);
    n_tests++;
    if (voice_active !== 4'b0001 || buzz !== 1'b0) begin
      n_fail++; $display("FAIL lat_load: active=%b buzz=%b expected 0001/0", voice_active, buzz);
    end
    @(negedge clk);
    n_tests++;
    if (buzz !== 1'b1) begin n_fail++; $display("FAIL lat_buzz: buzz=%b expected 1", buzz); end
    measure_tone(69, 100, "note69");
  endtask

  task automatic test_random_notes();
    for (int t = 0; t < 3; t++) begin
      int note, vel;
      note = $urandom_range(96, 127);
      vel  = $urandom_range(1, 127);
      do_reset();
      send_byte(8'h90); send_byte(8'(note)); send_byte(8'(vel));
      repeat (2) @(negedge clk);
      n_tests++;
      if (buzz !== 1'b1) begin n_fail++; $display("FAIL rnd_rise note %0d: buzz=%b expected 1", note, buzz); end
      measure_tone(note, vel, "rnd_note");
    end
  endtask

  task automatic test_running_status();
    do_reset();
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h40); send_byte(8'h40); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== 4'b0011) begin n_fail++; $display("FAIL running_on: active=%b expected 0011", voice_active); end
    send_byte(8'h3C); send_byte(8'h00);
    settle();
    n_tests++;
    if (voice_active !== 4'b0010 || buzz !== 1'b1) begin
      n_fail++; $display("FAIL running_off: active=%b buzz=%b expected 0010/1", voice_active, buzz);
    end
  endtask

  task automatic test_stealing();
    do_reset();
    send_byte(8'h90);
    send_byte(8'h3C); send_byte(8'h40); send_byte(8'h3E); send_byte(8'h40);
    send_byte(8'h40); send_byte(8'h40); send_byte(8'h41); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== 4'b1111) begin n_fail++; $display("FAIL steal_fill: active=%b expected 1111", voice_active); end
    send_byte(8'h43); send_byte(8'h40);
    send_byte(8'h45); send_byte(8'h40);
    send_byte(8'h80); send_byte(8'h45); send_byte(8'h00);
    settle();
    n_tests++;
    if (voice_active !== 4'b1101) begin n_fail++; $display("FAIL steal_69_v1: active=%b expected 1101", voice_active); end
    send_byte(8'h43); send_byte(8'h00);
    settle();
    n_tests++;
    if (voice_active !== 4'b1100) begin n_fail++; $display("FAIL steal_67_v0: active=%b expected 1100", voice_active); end
  endtask

  task automatic test_filtering();
    do_reset();
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hFE); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== 4'b0001) begin n_fail++; $display("FAIL filt_realtime: active=%b expected 0001", voice_active); end
    send_byte(8'h91); send_byte(8'h3E); send_byte(8'h40);
    send_byte(8'hB0); send_byte(8'h07); send_byte(8'h64);
    send_byte(8'h3E); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== 4'b0001) begin n_fail++; $display("FAIL filt_channel_cc: active=%b expected 0001", voice_active); end
    send_byte(8'h90); send_byte(8'h3E); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== 4'b0011) begin n_fail++; $display("FAIL filt_recover: active=%b expected 0011", voice_active); end
  endtask

  task automatic test_retrigger();
    int w;
    do_reset();
    send_byte(8'h90); send_byte(8'h78); send_byte(8'h40);
    w = 0;
    while (buzz !== 1'b0 && w < 3000) begin w++; @(negedge clk); end
    while (buzz !== 1'b1 && w < 3000) begin w++; @(negedge clk); end
    while (buzz !== 1'b0 && w < 3000) begin w++; @(negedge clk); end
    n_tests++;
    if (w >= 3000) begin n_fail++; $display("FAIL retrig_wait: buzz never reached low phase, waited %0d", w); end
    repeat (5) @(negedge clk);
    send_byte(8'h78); send_byte(8'h40);
    @(negedge clk);
    n_tests++;
    if (buzz !== 1'b0) begin n_fail++; $display("FAIL retrig_pre: buzz=%b expected 0", buzz); end
    @(negedge clk);
    n_tests++;
    if (buzz !== 1'b1 || voice_active !== 4'b0001) begin
      n_fail++; $display("FAIL retrig_phase: buzz=%b active=%b expected 1/0001", buzz, voice_active);
    end
    measure_tone(120, 64, "retrig");
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [$] = '{8'h90, 8'h3C, 8'h40, 8'h3E, 8'h40, 8'h40, 8'h40, 8'h80, 8'h3C, 8'h00};
    do_reset();
    @(negedge clk);
    foreach (seq[i]) begin
      rx_valid = 1'b1; rx_byte = seq[i]; model_byte(int'(seq[i]));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    settle();
    n_tests++;
    if (voice_active !== model_vec()) begin
      n_fail++; $display("FAIL b2b: active=%b expected %b", voice_active, model_vec());
    end
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int m = 0; m < 40; m++) begin
      int kind, note, vel;
      kind = $urandom_range(0, 5);
      note = 60 + $urandom_range(0, 5);
      vel  = 50 * $urandom_range(0, 2);
      case (kind)
        0: send_byte(8'h90);
        1: send_byte(8'h80);
        2: send_byte(8'h91);
        3: send_byte(8'hB0);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) send_byte(8'hF8);
      send_byte(8'(note));
      send_byte(8'(vel));
      settle();
      n_tests++;
      if (voice_active !== model_vec()) begin
        n_fail++; $display("FAIL random_msg %0d: active=%b expected %b", m, voice_active, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    send_byte(8'h90); send_byte(8'h78); send_byte(8'h40);
    repeat (2) @(negedge clk);
    n_tests++;
    if (buzz !== 1'b1) begin n_fail++; $display("FAIL areset_tone: buzz=%b expected 1", buzz); end
    send_byte(8'h90); send_byte(8'h3C);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (buzz !== 1'b0 || voice_active !== '0) begin
      n_fail++; $display("FAIL areset_async: buzz=%b active=%b expected 0/0000", buzz, voice_active);
    end
    @(negedge clk);
    rst = 1'b0; model_reset();
    send_byte(8'h40); send_byte(8'h45); send_byte(8'h40);
    settle();
    n_tests++;
    if (voice_active !== '0 || buzz !== 1'b0) begin
      n_fail++; $display("FAIL areset_partial: active=%b buzz=%b expected 0000/0", voice_active, buzz);
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_note_on_69();
    test_random_notes();
    test_running_status();
    test_stealing();
    test_filtering();
    test_retrigger();
    test_back_to_back();
    test_random_traffic();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
